nand4_sweep_ctrl: RTL

Self-checking sweep controller for the four-input NAND gate block. On `start` it drives all 16 input combinations onto the gate's `a`, `b`, `c`, `d` inputs and holds each one for a programmable settle time. At the end of each hold it compares the gate output against the expected NAND result, counting mismatches and recording the first failing vector. It sits beside the gate in the week-4 gate designs and replaces a free-running stimulus bench with a synthesizable, handshaked tester.

---
 rtl/nand4_sweep_ctrl_if.sv | 47 ++++
 rtl/nand4_sweep_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/nand4_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// nand4_sweep_ctrl_if
//
// Purpose: bundles the request/result handshake and the gate-facing signals
// of the NAND4 sweep controller.
//
// Signals:
//   start      requester -> controller : request a sweep
//   y          gate      -> controller : observed NAND output
//   a,b,c,d    controller -> gate      : vector bits 3..0
//   busy       controller -> requester : sweep in progress
//   done       controller -> requester : one-cycle completion pulse
//   pass       controller -> requester : last sweep had no mismatches
//   err_cnt    controller -> requester : mismatch count (0..16)
//   fail_seen  controller -> requester : at least one mismatch
//   fail_idx   controller -> requester : index of first mismatch
//   cap_vec    controller -> requester : captured y per vector
//
// Modports:
//   master : the requester side (also models the gate output y)
//   slave  : the sweep controller
// ---------------------------------------------------------------------------
interface nand4_sweep_ctrl_if;
    logic        start;
    logic        y;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic        fail_seen;
    logic [3:0]  fail_idx;
    logic [15:0] cap_vec;

    modport master (
        output start, y,
        input  a, b, c, d, busy, done, pass, err_cnt, fail_seen, fail_idx, cap_vec
    );

    modport slave (
        input  start, y,
        output a, b, c, d, busy, done, pass, err_cnt, fail_seen, fail_idx, cap_vec
    );
endinterface

// File: rtl/nand4_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nand4_sweep_ctrl
//
// Purpose: on start, walks all 16 input combinations onto a four-input NAND
// gate, holds each for SETTLE_CYCLES clocks and checks the gate output at
// the end of each hold. Counts mismatches, remembers the first failing
// vector and reports pass/fail with a one-cycle done pulse.
//
// Parameters:
//   SETTLE_CYCLES  hold time per vector in clocks (legal 1..15)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nand4_sweep_ctrl_if.slave (start, y, a..d, busy, done, pass,
//          err_cnt, fail_seen, fail_idx, cap_vec)
//
// Build option:
//   NAND4_SWEEP_CAPTURE_EN  when defined, the y sample of every vector is
//                           stored in cap_vec; otherwise cap_vec reads 0.
// ---------------------------------------------------------------------------
module nand4_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    nand4_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SC_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  sc_q, sc_d;
    logic [4:0]  err_cnt_q, err_cnt_d;
    logic        fail_seen_q, fail_seen_d;
    logic [3:0]  fail_idx_q, fail_idx_d;
    logic        pass_q, pass_d;
`ifdef NAND4_SWEEP_CAPTURE_EN
    logic [15:0] cap_vec_q, cap_vec_d;
`endif

    logic        compare_now;
    logic        y_expected;
    logic        mismatch;

    // Expected value comes from the registered vector, never from y history.
    assign compare_now = (state_q == RUN) && (sc_q == SC_LAST);
    assign y_expected  = ~(&vec_q);
    assign mismatch    = (bus.y != y_expected);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        sc_d        = sc_q;
        err_cnt_d   = err_cnt_q;
        fail_seen_d = fail_seen_q;
        fail_idx_d  = fail_idx_q;
        pass_d      = pass_q;
`ifdef NAND4_SWEEP_CAPTURE_EN
        cap_vec_d   = cap_vec_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    vec_d       = 4'd0;
                    sc_d        = 4'd0;
                    err_cnt_d   = 5'd0;
                    fail_seen_d = 1'b0;
                    fail_idx_d  = 4'd0;
                    pass_d      = 1'b0;
`ifdef NAND4_SWEEP_CAPTURE_EN
                    cap_vec_d   = 16'h0000;
`endif
                end
            end
            RUN: begin
                if (!compare_now) begin
                    sc_d = sc_q + 4'd1;
                end else begin
                    sc_d = 4'd0;
`ifdef NAND4_SWEEP_CAPTURE_EN
                    cap_vec_d[vec_q] = bus.y;
`endif
                    if (mismatch) begin
                        // Saturate rather than wrap; 16 is the natural maximum.
                        if (err_cnt_q != 5'h1F) begin
                            err_cnt_d = err_cnt_q + 5'd1;
                        end
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            fail_idx_d  = vec_q;
                        end
                    end
                    if (vec_q == 4'hF) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end
            end
            DONE: begin
                pass_d  = (err_cnt_q == 5'd0);
                vec_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= 4'd0;
            sc_q        <= 4'd0;
            err_cnt_q   <= 5'd0;
            fail_seen_q <= 1'b0;
            fail_idx_q  <= 4'd0;
            pass_q      <= 1'b0;
`ifdef NAND4_SWEEP_CAPTURE_EN
            cap_vec_q   <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            sc_q        <= sc_d;
            err_cnt_q   <= err_cnt_d;
            fail_seen_q <= fail_seen_d;
            fail_idx_q  <= fail_idx_d;
            pass_q      <= pass_d;
`ifdef NAND4_SWEEP_CAPTURE_EN
            cap_vec_q   <= cap_vec_d;
`endif
        end
    end

    assign bus.a         = vec_q[3];
    assign bus.b         = vec_q[2];
    assign bus.c         = vec_q[1];
    assign bus.d         = vec_q[0];
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.fail_seen = fail_seen_q;
    assign bus.fail_idx  = fail_idx_q;
`ifdef NAND4_SWEEP_CAPTURE_EN
    assign bus.cap_vec   = cap_vec_q;
`else
    assign bus.cap_vec   = 16'h0000;
`endif

endmodule
